// File: rtl/exu_bp_update_ctl_if.sv
// Branch-resolution, redirect and BHT-write signals between the EXU and the BHT update controller.
// The master side drives resolution packets and write-port ready. The slave side is the controller.
interface exu_bp_update_ctl_if #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
);
    logic             freeze;
    logic             res_valid;
    logic             res_misp;
    logic             res_ataken;
    logic [1:0]       res_hist;
    logic [IDX_W-1:0] res_index;
    logic             res_bank;
    logic             flush_upper;
    logic [30:0]      flush_path;
    logic             redir_valid;
    logic [30:0]      redir_pc;
    logic             bht_wr_valid;
    logic             bht_wr_ready;
    logic [IDX_W-1:0] bht_wr_index;
    logic             bht_wr_bank;
    logic [1:0]       bht_wr_hist;
    logic             fifo_full;
    logic [CNT_W-1:0] misp_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output freeze, res_valid, res_misp, res_ataken, res_hist, res_index, res_bank,
               flush_upper, flush_path, bht_wr_ready,
        input  redir_valid, redir_pc, bht_wr_valid, bht_wr_index, bht_wr_bank, bht_wr_hist,
               fifo_full, misp_cnt, drop_cnt
    );

    modport slave (
        input  freeze, res_valid, res_misp, res_ataken, res_hist, res_index, res_bank,
               flush_upper, flush_path, bht_wr_ready,
        output redir_valid, redir_pc, bht_wr_valid, bht_wr_index, bht_wr_bank, bht_wr_hist,
               fifo_full, misp_cnt, drop_cnt
    );
endinterface

// File: rtl/exu_bp_update_ctl.sv
// Registers the EXU flush redirect and queues BHT counter updates into a small coalescing FIFO.
// Redirect latency is 1 cycle. A queued write issues the cycle after its push, with no bypass.
// Backpressure: the head entry is held until bht_wr_ready. Pushes are dropped and counted when the FIFO is full with no pop.
module exu_bp_update_ctl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    exu_bp_update_ctl_if.slave bp
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             bank;
        logic [IDX_W-1:0] index;
        logic [1:0]       hist;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    last;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] misp_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             redir_valid;
    logic [30:0]      redir_pc;

    logic empty, full, accept, pop, coalesce, push, drop;
    entry_t new_entry;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign accept    = bp.res_valid & ~bp.freeze;
    assign pop       = ~empty & bp.bht_wr_ready;
    assign last      = tail - 1'b1;
    assign new_entry = '{bank: bp.res_bank, index: bp.res_index, hist: bp.res_hist};

    // The newest entry may be rewritten only if it is not leaving through the write port this cycle.
    assign coalesce = accept & ~empty
                    & ({mem[last].bank, mem[last].index} == {bp.res_bank, bp.res_index})
                    & ~(pop & (last == head));
    assign push     = accept & ~coalesce & (~full | pop);
    assign drop     = accept & ~coalesce & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            misp_cnt    <= '0;
            drop_cnt    <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else begin
            if (coalesce) mem[last].hist <= bp.res_hist;
            if (push) begin
                mem[tail] <= new_entry;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (accept & bp.res_misp & ~(&misp_cnt)) misp_cnt <= misp_cnt + 1'b1;
            if (drop & ~(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            redir_valid <= bp.flush_upper & ~bp.freeze;
            if (bp.flush_upper & ~bp.freeze) redir_pc <= bp.flush_path;
        end
    end

    assign bp.redir_valid  = redir_valid;
    assign bp.redir_pc     = redir_pc;
    assign bp.bht_wr_valid = ~empty;
    assign bp.bht_wr_index = mem[head].index;
    assign bp.bht_wr_bank  = mem[head].bank;
    assign bp.bht_wr_hist  = mem[head].hist;
    assign bp.fifo_full    = full;
    assign bp.misp_cnt     = misp_cnt;
    assign bp.drop_cnt     = drop_cnt;
endmodule

// File: tb/tb_exu_bp_update_ctl.sv
// Directed bench for exu_bp_update_ctl: expected BHT writes and redirects are queued by the stimulus
// and checked by a negedge monitor. Perf counters use a 4-bit width so saturation is reachable quickly.
module tb_exu_bp_update_ctl;
    localparam int IDX_W = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exu_bp_update_ctl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bp ();

    exu_bp_update_ctl #(.DEPTH(4), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    logic [10:0] wr_q [$];
    logic [30:0] redir_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a write handshake seen at the negedge completes on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bp.bht_wr_valid && bp.bht_wr_ready) begin
                if (wr_q.size() == 0)
                    chk("unexpected_bht_write", {bp.bht_wr_bank, bp.bht_wr_index, bp.bht_wr_hist}, 11'h7ff);
                else
                    chk("bht_write", {bp.bht_wr_bank, bp.bht_wr_index, bp.bht_wr_hist}, wr_q.pop_front());
            end
            if (!rst && bp.redir_valid) begin
                if (redir_q.size() == 0)
                    chk("unexpected_redirect", {32'd0, bp.redir_pc}, 64'hffff_ffff);
                else
                    chk("redirect_pc", {32'd0, bp.redir_pc}, {32'd0, redir_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] idx, input logic bank, input logic [1:0] hist, input logic misp);
        bp.res_valid = 1'b1;
        bp.res_index = idx;
        bp.res_bank  = bank;
        bp.res_hist  = hist;
        bp.res_misp  = misp;
        step();
        bp.res_valid = 1'b0;
        bp.res_misp  = 1'b0;
    endtask

    task automatic exp_wr(input logic [7:0] idx, input logic bank, input logic [1:0] hist);
        wr_q.push_back({bank, idx, hist});
    endtask

    task automatic drain(input int n);
        bp.bht_wr_ready = 1'b1;
        repeat (n) step();
        chk("drained_empty", bp.bht_wr_valid, 1'b0);
    endtask

    initial begin
        bp.freeze = 0; bp.res_valid = 0; bp.res_misp = 0; bp.res_ataken = 0;
        bp.res_hist = 0; bp.res_index = 0; bp.res_bank = 0;
        bp.flush_upper = 0; bp.flush_path = 0; bp.bht_wr_ready = 0;
        repeat (2) step();
        chk("rst_wr_valid", bp.bht_wr_valid, 1'b0);
        chk("rst_redir_valid", bp.redir_valid, 1'b0);
        chk("rst_full", bp.fifo_full, 1'b0);
        chk("rst_misp", bp.misp_cnt, 0);
        chk("rst_drop", bp.drop_cnt, 0);
        rst = 1'b0;
        step();

        // T1: single update, write issues the cycle after push
        bp.bht_wr_ready = 1'b1;
        exp_wr(8'h12, 1'b0, 2'b10);
        send(8'h12, 1'b0, 2'b10, 1'b0);
        chk("t1_valid_next", bp.bht_wr_valid, 1'b1);
        step();
        chk("t1_empty", bp.bht_wr_valid, 1'b0);

        // T2: fill, drop the fifth, drain in order
        bp.bht_wr_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_wr(8'(i), 1'b0, 2'b01);
            send(8'(i), 1'b0, 2'b01, 1'b1);
            if (i == 3) chk("t2_not_full", bp.fifo_full, 1'b0);
            if (i == 4) chk("t2_full", bp.fifo_full, 1'b1);
        end
        chk("t2_drop", bp.drop_cnt, 1);
        chk("t2_misp", bp.misp_cnt, 5);
        drain(5);

        // T3: same index coalesces into one write carrying the newest hist
        bp.bht_wr_ready = 1'b0;
        exp_wr(8'h20, 1'b0, 2'b11);
        send(8'h20, 1'b0, 2'b01, 1'b0);
        send(8'h20, 1'b0, 2'b11, 1'b0);
        chk("t3_not_full", bp.fifo_full, 1'b0);
        drain(3);

        // T4: redirect pulse, then frozen flush and packet are ignored
        bp.flush_upper = 1'b1;
        bp.flush_path  = 31'h2000_0008;
        redir_q.push_back(31'h2000_0008);
        step();
        bp.flush_upper = 1'b0;
        chk("t4_redir_valid", bp.redir_valid, 1'b1);
        step();
        chk("t4_redir_pulse", bp.redir_valid, 1'b0);
        bp.freeze = 1'b1;
        bp.flush_upper = 1'b1;
        bp.flush_path  = 31'h0000_1234;
        send(8'h33, 1'b1, 2'b11, 1'b1);
        bp.flush_upper = 1'b0;
        chk("t4_freeze_redir", bp.redir_valid, 1'b0);
        chk("t4_freeze_pc_hold", bp.redir_pc, 31'h2000_0008);
        chk("t4_freeze_no_push", bp.bht_wr_valid, 1'b0);
        chk("t4_freeze_misp", bp.misp_cnt, 5);
        bp.freeze = 1'b0;

        // T5: full FIFO with a pop and a distinct push in the same cycle
        bp.bht_wr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_wr(8'h40 + 8'(i), 1'b1, 2'b10);
            send(8'h40 + 8'(i), 1'b1, 2'b10, 1'b0);
        end
        chk("t5_full", bp.fifo_full, 1'b1);
        bp.bht_wr_ready = 1'b1;
        exp_wr(8'h45, 1'b1, 2'b00);
        send(8'h45, 1'b1, 2'b00, 1'b0);
        chk("t5_still_full", bp.fifo_full, 1'b1);
        chk("t5_no_drop", bp.drop_cnt, 1);
        drain(5);

        // T6: reset mid-drain discards queued entries
        bp.bht_wr_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_wr(8'h50 + 8'(i), 1'b0, 2'b11);
            send(8'h50 + 8'(i), 1'b0, 2'b11, 1'b1);
        end
        bp.bht_wr_ready = 1'b1;
        step();
        rst = 1'b1;
        #1;
        wr_q.delete();
        chk("t6_rst_valid", bp.bht_wr_valid, 1'b0);
        chk("t6_rst_misp", bp.misp_cnt, 0);
        step();
        rst = 1'b0;
        step();
        chk("t6_after_valid", bp.bht_wr_valid, 1'b0);
        chk("t6_after_full", bp.fifo_full, 1'b0);
        chk("t6_after_drop", bp.drop_cnt, 0);

        // Saturation: one coalesced entry, misp_cnt pins at all-ones
        bp.bht_wr_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(8'h60, 1'b1, 2'(i), 1'b1);
            if (i == 14) chk("sat_reach", bp.misp_cnt, 4'hf);
        end
        chk("sat_hold", bp.misp_cnt, 4'hf);
        exp_wr(8'h60, 1'b1, 2'(16));
        drain(3);

        chk("wr_queue_empty", wr_q.size(), 0);
        chk("redir_queue_empty", redir_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
